// File: rtl/trigger_pkg.sv
// trigger_pkg: shared types and parameter defaults for the trigger generator.
//   trg_mode_e   - per-channel mode (periodic / one-shot)
//   chan_state_e - one-shot channel state (IDLE / ARMED)
//   CH_DEF/CW_DEF - default channel count and counter width
package trigger_pkg;
  localparam int CH_DEF = 4;
  localparam int CW_DEF = 8;

  typedef enum logic {
    TRG_PERIODIC = 1'b0,
    TRG_ONESHOT  = 1'b1
  } trg_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chan_state_e;
endpackage

// File: rtl/trigger_gen_if.sv
// trigger_gen_if: control/status bundle of the trigger generator.
//   en, mode, start  - per-channel control (CH bits each)
//   period           - per-channel period, channel i in period[i]
//   trigger, busy    - per-channel registered status
// master drives control and reads status; slave is the generator side.
interface trigger_gen_if
  import trigger_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int CW = CW_DEF
);
  logic [CH-1:0]         en;
  logic [CH-1:0]         mode;
  logic [CH-1:0]         start;
  logic [CH-1:0][CW-1:0] period;
  logic [CH-1:0]         trigger;
  logic [CH-1:0]         busy;

  modport master (output en, mode, start, period, input trigger, busy);
  modport slave  (input en, mode, start, period, output trigger, busy);
endinterface

// File: rtl/trigger_chan.sv
// trigger_chan: one trigger channel (counter + one-shot state machine).
//   clk, reset - clock, synchronous active-low reset
//   nul_s      - synchronized clear, overrides everything but reset
//   en         - count enable; low freezes count and armed state
//   mode       - periodic or one-shot
//   start      - one-shot arm / restart pulse
//   period     - period in cycles, 0 disables the channel
//   trigger    - registered one-cycle pulse on terminal count
//   busy       - registered count-in-progress flag
module trigger_chan
  import trigger_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          nul_s,
  input  logic          en,
  input  trg_mode_e     mode,
  input  logic          start,
  input  logic [CW-1:0] period,
  output logic          trigger,
  output logic          busy
);
  logic [CW-1:0] cnt;
  chan_state_e   state;
  trg_mode_e     mode_q;
  logic          done;

  // >= rather than == so that shrinking period mid-count ends the count
  // on the next edge instead of wrapping through 2^CW.
  assign done = (period != '0) && (cnt >= period - CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      state   <= IDLE;
      trigger <= 1'b0;
      busy    <= 1'b0;
      mode_q  <= mode;
    end else begin
      mode_q  <= mode;
      trigger <= 1'b0;
      busy    <= (period != '0) &&
                 ((mode == TRG_ONESHOT) ? (state == ARMED) : en);
      if (nul_s || (mode != mode_q) || (period == '0)) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (mode == TRG_PERIODIC) begin
        state <= IDLE;
        if (en) begin
          cnt     <= done ? '0 : cnt + CW'(1);
          trigger <= done;
        end
      end else if (en) begin
        if (start) begin
          // arm from IDLE, or restart the count while ARMED
          state <= ARMED;
          cnt   <= '0;
        end else if (state == ARMED) begin
          if (done) begin
            cnt     <= '0;
            state   <= IDLE;
            trigger <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: rtl/trigger_gen.sv
// trigger_gen: CH independent periodic / one-shot trigger channels.
//   clk   - sole clock
//   reset - synchronous active-low reset
//   nul   - asynchronous clear request, synchronized here (2 flops)
//   bus   - trigger_gen_if.slave: en/mode/start/period in, trigger/busy out
module trigger_gen
  import trigger_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          nul,
  trigger_gen_if.slave  bus
);
  logic [1:0]    nul_pipe;
  logic          nul_s;
  logic [CH-1:0] trig_w;
  logic [CH-1:0] busy_w;

  always_ff @(posedge clk) begin
    if (!reset) nul_pipe <= '0;
    else        nul_pipe <= {nul_pipe[0], nul};
  end
  assign nul_s = nul_pipe[1];

  for (genvar i = 0; i < CH; i++) begin : g_chan
    trigger_chan #(.CW(CW)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .nul_s   (nul_s),
      .en      (bus.en[i]),
      .mode    (trg_mode_e'(bus.mode[i])),
      .start   (bus.start[i]),
      .period  (bus.period[i]),
      .trigger (trig_w[i]),
      .busy    (busy_w[i])
    );
  end

  assign bus.trigger = trig_w;
  assign bus.busy    = busy_w;
endmodule

// File: tb/tb_trigger_gen.sv
// tb_trigger_gen: directed scenarios with a per-cycle expectation queue.
module tb_trigger_gen;
  import trigger_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic nul;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] trig;
    logic [3:0] busy;
  } exp_t;
  exp_t exp_q[$];

  trigger_gen_if #(.CH(4), .CW(8)) bif ();

  trigger_gen #(.CH(4), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .nul   (nul),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Queue the expectation for the coming edge, then compare after it.
  task automatic step(input string tag, input logic [3:0] et, input logic [3:0] eb);
    exp_t x;
    x.tag = tag; x.trig = et; x.busy = eb;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk({x.tag, ".trig"}, 32'(bif.trigger), 32'(x.trig));
    chk({x.tag, ".busy"}, 32'(bif.busy), 32'(x.busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; nul = 1'b0;
    bif.en = '0; bif.mode = 4'b0010; bif.start = '0; bif.period = '0;

    // reset; ch0 periodic period 4 already enabled on the last reset edge
    step("rst", 4'b0, 4'b0);
    bif.en[0] = 1'b1; bif.period[0] = 8'd4;
    step("rst", 4'b0, 4'b0);
    reset = 1'b1;
    for (int e = 1; e <= 13; e++)
      step("per4", {3'b0, (e % 4) == 0}, 4'b0001);
    bif.en[0] = 1'b0; bif.period[0] = 8'd0;
    step("clr", 4'b0, 4'b0);

    // one-shot ch1 period 5
    bif.en[1] = 1'b1; bif.period[1] = 8'd5;
    step("os_idle", 4'b0, 4'b0);
    step("os_idle", 4'b0, 4'b0);
    bif.start[1] = 1'b1;
    step("os_arm", 4'b0, 4'b0);
    bif.start[1] = 1'b0;
    for (int e = 1; e <= 5; e++)
      step("os5", (e == 5) ? 4'b0010 : 4'b0, 4'b0010);
    for (int e = 0; e < 3; e++)
      step("os_done", 4'b0, 4'b0);
    bif.en[1] = 1'b0; bif.period[1] = 8'd0;

    // nul pulse while ch0 counts period 3: clears two edges later
    bif.en[0] = 1'b1; bif.period[0] = 8'd3;
    for (int e = 1; e <= 14; e++) begin
      logic t;
      nul = (e == 5);
      t = (e < 7) ? ((e % 3) == 0) : ((e > 7) && ((e - 7) % 3) == 0);
      step("nul", {3'b0, t}, 4'b0001);
    end
    nul = 1'b0;
    bif.en[0] = 1'b0; bif.period[0] = 8'd0;
    step("clr", 4'b0, 4'b0);

    // period 10 shrunk to 2 once cnt reaches 7
    bif.en[0] = 1'b1; bif.period[0] = 8'd10;
    for (int e = 1; e <= 14; e++) begin
      if (e == 8) bif.period[0] = 8'd2;
      step("shrink", {3'b0, (e >= 8) && ((e - 8) % 2) == 0}, 4'b0001);
    end

    // period 1 holds trigger high; period 0 holds everything low
    bif.period[0] = 8'd1;
    step("p1_first", 4'b0001, 4'b0001);  // cnt 0 is already terminal
    for (int e = 0; e < 4; e++)
      step("p1", 4'b0001, 4'b0001);
    bif.period[0] = 8'd0;
    for (int e = 0; e < 4; e++)
      step("p0", 4'b0, 4'b0);
    bif.en[0] = 1'b0;

    // reset during one-shot ch1 (period 6) at cnt 3
    bif.en[1] = 1'b1; bif.period[1] = 8'd6;
    bif.start[1] = 1'b1;
    step("rs_arm", 4'b0, 4'b0);
    bif.start[1] = 1'b0;
    for (int e = 1; e <= 3; e++)
      step("rs_cnt", 4'b0, 4'b0010);
    reset = 1'b0;
    step("rs_rst", 4'b0, 4'b0);
    reset = 1'b1;
    for (int e = 0; e < 8; e++)
      step("rs_idle", 4'b0, 4'b0);

    // re-arm, then restart at cnt 3: trigger 6 edges after the restart
    bif.start[1] = 1'b1;
    step("rs_arm2", 4'b0, 4'b0);
    bif.start[1] = 1'b0;
    for (int e = 1; e <= 3; e++)
      step("rs_cnt2", 4'b0, 4'b0010);
    bif.start[1] = 1'b1;
    step("restart", 4'b0, 4'b0010);
    bif.start[1] = 1'b0;
    for (int e = 1; e <= 6; e++)
      step("restart6", (e == 6) ? 4'b0010 : 4'b0, 4'b0010);
    step("rs_end", 4'b0, 4'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
